// File: rtl/z80_mem_arbiter_pkg.sv
// Shared types for the Z80 / video block-RAM arbiter: FSM encoding and
// data-bus direction levels for the SB_IO output enable.
package z80_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_VID_RD  = 3'd1,
      ST_Z_RD    = 3'd2,
      ST_Z_DRIVE = 3'd3,
      ST_Z_WR    = 3'd4,
      ST_Z_END   = 3'd5
   } arb_state_t;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

endpackage

// File: rtl/z80_mem_arbiter_bus_sync.sv
// Two-flop synchroniser for the asynchronous Z80 strobes. Flops reset to 1
// so every active-low strobe reads as inactive out of reset.
module z80_mem_arbiter_bus_sync #(
   parameter int W = 5
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [W-1:0] async_in,
   output logic [W-1:0] sync_out
);

   logic [W-1:0] meta;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         meta     <= '1;
         sync_out <= '1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Shares one single-port block RAM between the Z80 memory window and a video
// fetch port. The Z80 always has priority; video is served only from IDLE.
module z80_mem_arbiter
   import z80_mem_arbiter_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h8000,
   parameter int          AW        = 13,
   parameter int          ACT_LEN   = 24
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [15:0]   A,
   input  logic          MRQ,
   input  logic          IORQ,
   input  logic          RD,
   input  logic          WR,
   input  logic          M1,
   input  logic [7:0]    d_in,
   output logic [7:0]    d_out,
   output logic          DATA_DIR,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic          ram_we,
   input  logic [7:0]    ram_rdata,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [7:0]    vid_data,
   output logic          LED1
);

   logic mrq_s, iorq_s, rd_s, wr_s, m1_s;

   z80_mem_arbiter_bus_sync #(.W(5)) u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in ({MRQ, IORQ, RD, WR, M1}),
      .sync_out ({mrq_s, iorq_s, rd_s, wr_s, m1_s})
   );

   // 17-bit offset: a borrow in bit 16 means A is below the window, so the
   // range test cannot wrap past FFFF.
   logic [16:0] off;
   logic        int_ack;
   logic        hit;

   assign off     = {1'b0, A} - {1'b0, BASE_ADDR};
   assign int_ack = !m1_s && !iorq_s;
   assign hit     = !mrq_s && iorq_s && !int_ack && (off[16:AW] == '0);

   arb_state_t         state, state_nxt;
   logic               run_q;
   logic               go_rd, go_wr, go_vid;
   logic [AW-1:0]      addr_q;
   logic               we_q;
   logic [7:0]         wdata_q;
   logic [7:0]         dout_q;
   logic               dir_q;
   logic               ack_q;
   logic [7:0]         vdata_q;
   logic [ACT_LEN-1:0] act_q;

   // The grant address goes to the RAM in the IDLE cycle itself so a
   // synchronous RAM has the byte ready by the end of Z_RD / VID_RD.
   always_comb begin
      state_nxt = state;
      go_rd     = 1'b0;
      go_wr     = 1'b0;
      go_vid    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hit && !rd_s) begin
               go_rd     = 1'b1;
               state_nxt = ST_Z_RD;
            end else if (hit && !wr_s) begin
               go_wr     = 1'b1;
               state_nxt = ST_Z_WR;
            end else if (run_q && vid_req && !ack_q) begin
               go_vid    = 1'b1;
               state_nxt = ST_VID_RD;
            end
         end
         ST_VID_RD:  state_nxt = ST_IDLE;
         ST_Z_RD:    state_nxt = ST_Z_DRIVE;
         ST_Z_DRIVE: if (rd_s || mrq_s) state_nxt = ST_Z_END;
         ST_Z_WR:    state_nxt = ST_Z_END;
         ST_Z_END:   if (mrq_s) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase

      ram_addr = addr_q;
      if (go_rd || go_wr)
         ram_addr = off[AW-1:0];
      else if (go_vid)
         ram_addr = vid_addr;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= ST_IDLE;
         run_q   <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         dout_q  <= '0;
         dir_q   <= DIR_IN;
         ack_q   <= 1'b0;
         vdata_q <= '0;
         act_q   <= '0;
      end else begin
         state  <= state_nxt;
         run_q  <= 1'b1;
         addr_q <= ram_addr;
         we_q   <= go_wr;
         if (go_wr)
            wdata_q <= d_in;

         // A request withdrawn during VID_RD gets no ack.
         ack_q <= (state == ST_VID_RD) && vid_req;
         if (state == ST_VID_RD && vid_req)
            vdata_q <= ram_rdata;

         if (state == ST_Z_RD) begin
            dout_q <= ram_rdata;
            dir_q  <= DIR_OUT;
         end else if (state == ST_Z_DRIVE && (rd_s || mrq_s)) begin
            dir_q  <= DIR_IN;
         end

         if (go_rd || go_wr)
            act_q <= '1;
         else if (act_q != '0)
            act_q <= act_q - ACT_LEN'(1);
      end
   end

   assign d_out     = dout_q;
   assign DATA_DIR  = dir_q;
   assign ram_we    = we_q;
   assign ram_wdata = wdata_q;
   assign vid_ack   = ack_q;
   assign vid_data  = vdata_q;
   assign LED1      = (act_q != '0);

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Bench for z80_mem_arbiter: synchronous RAM model, Z80 bus and video
// requester drivers, and a reference memory image built from the bus rules.
module tb_z80_mem_arbiter;

   localparam int AW    = 13;
   localparam int ACT   = 6;
   localparam int BASE  = 32'h8000;
   localparam int DEPTH = 1 << AW;

   logic          CLK, RST;
   logic [15:0]   A;
   logic          MRQ, IORQ, RD, WR, M1;
   logic [7:0]    d_in, d_out;
   logic          DATA_DIR;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata, ram_rdata;
   logic          ram_we;
   logic          vid_req, vid_ack;
   logic [AW-1:0] vid_addr;
   logic [7:0]    vid_data;
   logic          LED1;

   z80_mem_arbiter #(.BASE_ADDR(16'h8000), .AW(AW), .ACT_LEN(ACT)) dut (
      .CLK(CLK), .RST(RST), .A(A), .MRQ(MRQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1),
      .d_in(d_in), .d_out(d_out), .DATA_DIR(DATA_DIR),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .LED1(LED1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // RAM: unwritten locations return a seeded pattern; bd_* is a backdoor preload.
   logic [7:0]    seed;
   logic [7:0]    mem    [0:DEPTH-1];
   bit            mem_ok [0:DEPTH-1];
   logic [7:0]    ref_mem[0:DEPTH-1];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [7:0]    bd_data;

   function automatic logic [7:0] pat(input int a);
      return 8'((a * 29) ^ (a >> 7) ^ int'(seed));
   endfunction

   always @(posedge CLK) begin
      if (bd_we) begin
         mem[bd_addr]    <= bd_data;
         mem_ok[bd_addr] <= 1'b1;
      end else if (ram_we) begin
         mem[ram_addr]    <= ram_wdata;
         mem_ok[ram_addr] <= 1'b1;
      end
      ram_rdata <= mem_ok[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
   end

   int            cyc = 0, we_cnt = 0, dir_cnt = 0, ack_cnt = 0;
   logic [AW-1:0] we_addr;
   logic [7:0]    we_data;

   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) begin
      if (ram_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= ram_addr;
         we_data <= ram_wdata;
      end
      if (DATA_DIR) dir_cnt <= dir_cnt + 1;
      if (vid_ack)  ack_cnt <= ack_cnt + 1;
   end

   // Z80 read bus cycle; optionally with WR also low (illegal combination).
   task automatic z80_read(input logic [15:0] addr, input logic also_wr,
                           output logic [7:0] data, output int lat,
                           output logic drv, output int dcyc);
      @(negedge CLK);
      A = addr; MRQ = 1'b0; RD = 1'b0;
      if (also_wr) begin WR = 1'b0; d_in = 8'hFF; end
      lat = 0; drv = 1'b0; dcyc = 0;
      while (!drv && lat < 8) begin
         @(negedge CLK);
         lat++;
         if (DATA_DIR) begin drv = 1'b1; dcyc = cyc; end
      end
      repeat (2) @(negedge CLK);
      data = d_out;
      RD = 1'b1; WR = 1'b1; MRQ = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic z80_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge CLK);
      A = addr; d_in = data; MRQ = 1'b0; WR = 1'b0;
      repeat (6) @(negedge CLK);
      WR = 1'b1; MRQ = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic vid_fetch(input logic [AW-1:0] addr, input int delay,
                            output logic got, output logic [7:0] data, output int acyc);
      repeat (delay) @(negedge CLK);
      vid_addr = addr; vid_req = 1'b1;
      got = 1'b0; data = 8'h00; acyc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge CLK);
         if (vid_ack) begin got = 1'b1; data = vid_data; acyc = cyc; end
      end
      vid_req = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b0; vid_req = 1'b1; vid_addr = 13'h1ABC;
      repeat (3) @(negedge CLK);
      n_cmp++; if (DATA_DIR !== 1'b0) begin n_bad++; $display("FAIL reset_dir got=%b exp=0", DATA_DIR); end
      n_cmp++; if (d_out !== 8'h00) begin n_bad++; $display("FAIL reset_dout got=%h exp=00", d_out); end
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", ram_we); end
      n_cmp++; if (vid_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", vid_ack); end
      n_cmp++; if (vid_data !== 8'h00) begin n_bad++; $display("FAIL reset_vdata got=%h exp=00", vid_data); end
      n_cmp++; if (ram_addr !== '0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
      n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL reset_led got=%b exp=0", LED1); end
      vid_req = 1'b0;
      @(negedge CLK); RST = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_read;
      logic [7:0] got; int lat, dc; logic drv;
      @(negedge CLK); bd_we = 1'b1; bd_addr = 13'h0005; bd_data = 8'hA5;
      @(negedge CLK); bd_we = 1'b0;
      ref_mem[5] = 8'hA5;
      z80_read(16'h8005, 1'b0, got, lat, drv, dc);
      n_cmp++; if (drv !== 1'b1 || lat > 5) begin n_bad++; $display("FAIL read_latency drove=%b lat=%0d exp drove=1 lat<=5", drv, lat); end
      n_cmp++; if (got !== 8'hA5) begin n_bad++; $display("FAIL read_data got=%h exp=a5", got); end
      n_cmp++; if (DATA_DIR !== 1'b0) begin n_bad++; $display("FAIL read_release_dir got=%b exp=0", DATA_DIR); end
      n_cmp++; if (LED1 !== 1'b1) begin n_bad++; $display("FAIL read_led got=%b exp=1", LED1); end
   endtask

   task automatic test_write;
      int w0, d0;
      w0 = we_cnt; d0 = dir_cnt;
      z80_write(16'h8010, 8'h3C);
      ref_mem[16] = 8'h3C;
      n_cmp++; if (we_cnt - w0 !== 1) begin n_bad++; $display("FAIL write_pulses got=%0d exp=1", we_cnt - w0); end
      n_cmp++; if (we_addr !== 13'h0010) begin n_bad++; $display("FAIL write_addr got=%h exp=0010", we_addr); end
      n_cmp++; if (we_data !== 8'h3C) begin n_bad++; $display("FAIL write_data got=%h exp=3c", we_data); end
      n_cmp++; if (dir_cnt - d0 !== 0) begin n_bad++; $display("FAIL write_dir cycles=%0d exp=0", dir_cnt - d0); end
   endtask

   task automatic test_window;
      logic [15:0] miss [3];
      logic [15:0] edge_a [2];
      logic [7:0]  got; int lat, dc, w0, d0, o; logic drv;
      miss[0] = 16'h7FFF; miss[1] = 16'hA000; miss[2] = 16'hFFFF;
      edge_a[0] = 16'h8000; edge_a[1] = 16'h9FFF;
      for (int i = 0; i < 200 && LED1; i++) @(negedge CLK);
      n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL led_idle got=%b exp=0", LED1); end
      foreach (miss[i]) begin
         w0 = we_cnt; d0 = dir_cnt;
         z80_read(miss[i], 1'b0, got, lat, drv, dc);
         n_cmp++; if (dir_cnt - d0 !== 0 || we_cnt - w0 !== 0 || LED1 !== 1'b0)
            begin n_bad++; $display("FAIL window_miss a=%h dir=%0d we=%0d led=%b exp 0/0/0", miss[i], dir_cnt - d0, we_cnt - w0, LED1); end
      end
      foreach (edge_a[i]) begin
         o = int'(edge_a[i]) - BASE;
         z80_read(edge_a[i], 1'b0, got, lat, drv, dc);
         n_cmp++; if (drv !== 1'b1 || got !== ref_mem[o])
            begin n_bad++; $display("FAIL window_edge a=%h drove=%b got=%h exp=%h", edge_a[i], drv, got, ref_mem[o]); end
      end
   endtask

   task automatic test_vid_priority;
      logic [7:0] zd, vd; int lat, dc, ac; logic drv, got;
      fork
         z80_read(16'h8005, 1'b0, zd, lat, drv, dc);
         vid_fetch(13'h1FFF, 3, got, vd, ac);
      join
      n_cmp++; if (drv !== 1'b1 || zd !== ref_mem[5]) begin n_bad++; $display("FAIL prio_z80 drove=%b got=%h exp=%h", drv, zd, ref_mem[5]); end
      n_cmp++; if (got !== 1'b1 || vd !== ref_mem[DEPTH-1]) begin n_bad++; $display("FAIL prio_vid ack=%b got=%h exp=%h", got, vd, ref_mem[DEPTH-1]); end
      n_cmp++; if (!(dc < ac)) begin n_bad++; $display("FAIL prio_order dir_cyc=%0d ack_cyc=%0d exp dir first", dc, ac); end
   endtask

   task automatic test_int_ack;
      int w0, d0;
      w0 = we_cnt; d0 = dir_cnt;
      @(negedge CLK); A = 16'h8000; M1 = 1'b0; IORQ = 1'b0;
      repeat (6) @(negedge CLK);
      MRQ = 1'b0; RD = 1'b0;
      repeat (6) @(negedge CLK);
      M1 = 1'b1; IORQ = 1'b1; MRQ = 1'b1; RD = 1'b1;
      repeat (4) @(negedge CLK);
      n_cmp++; if (dir_cnt - d0 !== 0) begin n_bad++; $display("FAIL intack_dir cycles=%0d exp=0", dir_cnt - d0); end
      n_cmp++; if (we_cnt - w0 !== 0) begin n_bad++; $display("FAIL intack_we pulses=%0d exp=0", we_cnt - w0); end
   endtask

   task automatic test_illegal;
      logic [7:0] got; int lat, dc, w0; logic drv;
      w0 = we_cnt;
      z80_read(16'h8010, 1'b1, got, lat, drv, dc);
      n_cmp++; if (drv !== 1'b1 || got !== ref_mem[16]) begin n_bad++; $display("FAIL rdwr_read drove=%b got=%h exp=%h", drv, got, ref_mem[16]); end
      n_cmp++; if (we_cnt - w0 !== 0) begin n_bad++; $display("FAIL rdwr_we pulses=%0d exp=0", we_cnt - w0); end
   endtask

   task automatic test_vid_abandon;
      logic got; logic [7:0] vd; int ac, a0;
      a0 = ack_cnt;
      @(negedge CLK); vid_addr = 13'h0000; vid_req = 1'b1;
      @(negedge CLK); vid_req = 1'b0;
      repeat (10) @(negedge CLK);
      n_cmp++; if (ack_cnt - a0 !== 0) begin n_bad++; $display("FAIL vid_abandon acks=%0d exp=0", ack_cnt - a0); end
      vid_fetch(13'h0123, 0, got, vd, ac);
      n_cmp++; if (got !== 1'b1 || vd !== ref_mem[13'h0123]) begin n_bad++; $display("FAIL vid_fetch ack=%b got=%h exp=%h", got, vd, ref_mem[13'h0123]); end
   endtask

   task automatic test_led_decay;
      int n; logic seen;
      seen = 1'b0; n = 0;
      @(negedge CLK); A = 16'h8020; d_in = 8'h5A; MRQ = 1'b0; WR = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         if (ram_we) seen = 1'b1;
      end
      WR = 1'b1; MRQ = 1'b1;
      ref_mem[32] = 8'h5A;
      if (seen) begin
         n = 1;
         for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!LED1) break;
            n++;
         end
      end
      n_cmp++; if (n !== (1 << ACT) - 1) begin n_bad++; $display("FAIL led_decay high_cycles=%0d exp=%0d", n, (1 << ACT) - 1); end
   endtask

   task automatic test_reset_drive;
      logic drv; logic [7:0] got; int lat, dc;
      drv = 1'b0;
      @(negedge CLK); A = 16'h8005; MRQ = 1'b0; RD = 1'b0;
      for (int i = 0; i < 8 && !drv; i++) begin
         @(negedge CLK);
         if (DATA_DIR) drv = 1'b1;
      end
      n_cmp++; if (drv !== 1'b1) begin n_bad++; $display("FAIL rstdrv_setup drove=%b exp=1", drv); end
      #2 RST = 1'b0;
      #1;
      n_cmp++; if (DATA_DIR !== 1'b0 || d_out !== 8'h00 || LED1 !== 1'b0)
         begin n_bad++; $display("FAIL rstdrv_async dir=%b dout=%h led=%b exp 0/00/0", DATA_DIR, d_out, LED1); end
      MRQ = 1'b1; RD = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      z80_read(16'h8005, 1'b0, got, lat, drv, dc);
      n_cmp++; if (drv !== 1'b1 || got !== ref_mem[5]) begin n_bad++; $display("FAIL rstdrv_recover drove=%b got=%h exp=%h", drv, got, ref_mem[5]); end
   endtask

   task automatic test_random;
      logic [15:0] addr; logic [7:0] dat, got, vd; logic [AW-1:0] va;
      int lat, dc, ac, w0, d0, o; logic drv, vg; bit exp_hit;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(3))
            0, 1:    addr = 16'h8000 + 16'($urandom_range(DEPTH - 1));
            2:       addr = ($urandom_range(1) == 1) ? 16'h7FFC + 16'($urandom_range(3))
                                                     : 16'h9FFE + 16'($urandom_range(3));
            default: addr = 16'($urandom);
         endcase
         o = int'(addr) - BASE;
         exp_hit = (o >= 0) && (o < DEPTH);
         dat = 8'($urandom);
         w0 = we_cnt; d0 = dir_cnt;
         if ($urandom_range(1) == 1) begin
            z80_read(addr, 1'b0, got, lat, drv, dc);
            n_cmp++;
            if (drv !== exp_hit || (exp_hit && got !== ref_mem[o]) || (!exp_hit && dir_cnt - d0 !== 0))
               begin n_bad++; $display("FAIL rand_read a=%h drove=%b got=%h exp_hit=%b exp=%h", addr, drv, got, exp_hit, exp_hit ? ref_mem[o] : 8'h00); end
         end else begin
            z80_write(addr, dat);
            n_cmp++;
            if (we_cnt - w0 !== int'(exp_hit) || dir_cnt - d0 !== 0 ||
                (exp_hit && (we_addr !== AW'(o) || we_data !== dat)))
               begin n_bad++; $display("FAIL rand_write a=%h pulses=%0d dir=%0d waddr=%h wdata=%h exp_hit=%b exp_data=%h", addr, we_cnt - w0, dir_cnt - d0, we_addr, we_data, exp_hit, dat); end
            if (exp_hit) ref_mem[o] = dat;
         end
         if (it % 4 == 3) begin
            va = AW'($urandom);
            vid_fetch(va, 0, vg, vd, ac);
            n_cmp++; if (vg !== 1'b1 || vd !== ref_mem[va]) begin n_bad++; $display("FAIL rand_vid a=%h ack=%b got=%h exp=%h", va, vg, vd, ref_mem[va]); end
         end
      end
   endtask

   initial begin
      RST = 1'b0; A = 16'h0000; MRQ = 1'b1; IORQ = 1'b1; RD = 1'b1; WR = 1'b1; M1 = 1'b1;
      d_in = 8'h00; vid_req = 1'b0; vid_addr = '0; bd_we = 1'b0; bd_addr = '0; bd_data = 8'h00;
      seed = 8'($urandom);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
      test_reset;
      test_read;
      test_write;
      test_window;
      test_vid_priority;
      test_int_ack;
      test_illegal;
      test_vid_abandon;
      test_led_decay;
      test_reset_drive;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
